// File: rtl/uc_pkg.sv
// Shared definitions for the nRISC multi-cycle control unit: opcodes, ULA op codes,
// FSM state type and the registered control-word layout.
package uc_pkg;

  localparam logic [2:0] OP_LW   = 3'b000;
  localparam logic [2:0] OP_SW   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SLT = 3'b110;
  localparam logic [2:0] ULA_BEQ = 3'b111;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_src;
    logic       ula_src;
    logic [2:0] ula_op;
    logic       mem_read;
    logic       mem_write;
    logic       jump;
    logic       beq;
    logic       illegal_op;
    logic       mem_err;
  } ctrl_t;

endpackage

// File: rtl/uc_mem_timer.sv
// Data-memory wait counter: clear on MEM entry, count not-ready cycles, flag the last
// allowed wait cycle. MEM_TIMEOUT = 0 never expires.
module uc_mem_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int unsigned TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [TW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // Expire while sitting in the MEM_TIMEOUT-th wait cycle, so exactly MEM_TIMEOUT cycles are spent in MEM.
  if (MEM_TIMEOUT == 0) begin : g_no_timeout
    assign expire = 1'b0;
  end else begin : g_timeout
    assign expire = (count == TW'(MEM_TIMEOUT - 1));
  end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control FSM for the nRISC datapath (FETCH/DECODE/EXEC/MEM/WB).
// Define UC_INSTR_COUNT_EN to build the retired-instruction counter; otherwise instr_count is 0.
module unidade_controle_multiciclo
  import uc_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 3,
  parameter int unsigned ULAOP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                reg_src,
  output logic                ula_src,
  output logic [ULAOP_W-1:0]  ula_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic                jump,
  output logic                beq,
  output logic                illegal_op,
  output logic                mem_err,
  output logic [CNT_W-1:0]    instr_count
);

  state_t     state, state_nx;
  logic [2:0] op_q, op_nx;
  logic       boot;
  ctrl_t      ctrl_q, ctrl_nx;
  logic       illegal;
  logic       timer_clr, timer_inc, timer_expire;

  assign illegal = (opcode[2:0] == OP_ILL) || ((opcode >> 3) != '0);

  uc_mem_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (enable & timer_clr),
    .inc    (enable & timer_inc),
    .expire (timer_expire)
  );

  // boot=0 means the FSM sits in FETCH without having issued it yet, so the first
  // enabled edge after reset re-enters FETCH and emits its strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= FETCH;
      op_q   <= '0;
      boot   <= 1'b0;
      ctrl_q <= '0;
    end else if (enable) begin
      state  <= state_nx;
      op_q   <= op_nx;
      boot   <= 1'b1;
      ctrl_q <= ctrl_nx;
    end else begin
      ctrl_q.pc_write   <= 1'b0;
      ctrl_q.ir_write   <= 1'b0;
      ctrl_q.reg_write  <= 1'b0;
      ctrl_q.mem_write  <= 1'b0;
      ctrl_q.illegal_op <= 1'b0;
      ctrl_q.mem_err    <= 1'b0;
    end
  end

  always_comb begin
    state_nx  = state;
    op_nx     = op_q;
    ctrl_nx   = '0;
    timer_clr = 1'b0;
    timer_inc = 1'b0;

    if (!boot) begin
      state_nx = FETCH;
    end else begin
      case (state)
        FETCH:  state_nx = DECODE;
        DECODE: begin
          op_nx = opcode[2:0];
          if (illegal) begin
            state_nx           = FETCH;
            ctrl_nx.illegal_op = 1'b1;
          end else begin
            state_nx = EXEC;
          end
        end
        EXEC: begin
          case (op_q)
            OP_LW, OP_SW: begin
              state_nx  = MEM;
              timer_clr = 1'b1;
            end
            OP_JMP, OP_BEQ: state_nx = FETCH;
            default:        state_nx = WB;
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            state_nx = (op_q == OP_LW) ? WB : FETCH;
          end else if (timer_expire) begin
            state_nx        = FETCH;
            ctrl_nx.mem_err = 1'b1;
          end else begin
            timer_inc = 1'b1;
          end
        end
        WB:      state_nx = FETCH;
        default: state_nx = FETCH;
      endcase
    end

    // Outputs are decoded from the state being entered so they are valid in its first cycle.
    case (state_nx)
      FETCH: begin
        ctrl_nx.ir_write = 1'b1;
        ctrl_nx.pc_write = 1'b1;
      end
      EXEC: begin
        case (op_nx)
          OP_LW, OP_SW: begin
            ctrl_nx.ula_src = 1'b1;
            ctrl_nx.ula_op  = ULA_ADD;
          end
          OP_ADD:  ctrl_nx.ula_op = ULA_ADD;
          OP_ADDI: ctrl_nx.ula_src = 1'b1;
          OP_SLT:  ctrl_nx.ula_op = ULA_SLT;
          OP_JMP: begin
            ctrl_nx.jump     = 1'b1;
            ctrl_nx.pc_write = 1'b1;
          end
          OP_BEQ: begin
            ctrl_nx.ula_op   = ULA_BEQ;
            ctrl_nx.jump     = 1'b1;
            ctrl_nx.beq      = 1'b1;
            ctrl_nx.pc_write = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        ctrl_nx.mem_read  = (op_nx == OP_LW);
        ctrl_nx.mem_write = (op_nx == OP_SW);
      end
      WB: begin
        ctrl_nx.reg_write = 1'b1;
        ctrl_nx.reg_src   = (op_nx != OP_LW);
      end
      default: ;
    endcase
  end

  assign pc_write   = ctrl_q.pc_write;
  assign ir_write   = ctrl_q.ir_write;
  assign reg_write  = ctrl_q.reg_write;
  assign reg_src    = ctrl_q.reg_src;
  assign ula_src    = ctrl_q.ula_src;
  assign ula_op     = ULAOP_W'(ctrl_q.ula_op);
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign jump       = ctrl_q.jump;
  assign beq        = ctrl_q.beq;
  assign illegal_op = ctrl_q.illegal_op;
  assign mem_err    = ctrl_q.mem_err;

`ifdef UC_INSTR_COUNT_EN
  logic [CNT_W-1:0] count_q;
  logic             retire;

  assign retire = (state == WB)
               || (state == EXEC && (op_q == OP_JMP || op_q == OP_BEQ))
               || (state == MEM && mem_ready && op_q == OP_SW);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (enable && boot && retire) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for unidade_controle_multiciclo: per-instruction expected output
// traces are built from the instruction rules and compared cycle by cycle.
module tb_unidade_controle_multiciclo;

  localparam int unsigned OW = 4;
  localparam int unsigned UW = 3;
  localparam int unsigned TO = 15;
  localparam int unsigned CW = 4;

  logic          clock = 1'b0;
  logic          reset, enable, mem_ready;
  logic [OW-1:0] opcode;
  logic          pc_write, ir_write, reg_write, reg_src, ula_src;
  logic [UW-1:0] ula_op;
  logic          mem_read, mem_write, jump, beq, illegal_op, mem_err;
  logic [CW-1:0] instr_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct packed {
    logic       pc, ir, rw, rs, us;
    logic [2:0] uop;
    logic       mr, mw, j, b, ill, err;
  } vec_t;

  vec_t        exp_q[$];
  int unsigned exp_count = 0;
  bit          pend_ill = 0, pend_err = 0;
  bit          nxt_ill, nxt_err, nxt_ret;
  int unsigned mem_len;

  always #5 clock = ~clock;

  unidade_controle_multiciclo #(
    .OPCODE_W(OW),
    .ULAOP_W(UW),
    .MEM_TIMEOUT(TO),
    .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .reg_src(reg_src),
    .ula_src(ula_src), .ula_op(ula_op), .mem_read(mem_read), .mem_write(mem_write),
    .jump(jump), .beq(beq), .illegal_op(illegal_op), .mem_err(mem_err),
    .instr_count(instr_count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t observed();
    return {pc_write, ir_write, reg_write, reg_src, ula_src, ula_op,
            mem_read, mem_write, jump, beq, illegal_op, mem_err};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected cycle-by-cycle outputs of one instruction, starting at its FETCH cycle.
  function automatic void build(input logic [OW-1:0] op, input int unsigned wait_n);
    vec_t        v;
    int unsigned low;
    low = int'(op) % 8;
    exp_q.delete();
    nxt_ill = 0; nxt_err = 0; nxt_ret = 0; mem_len = 0;
    v = '0; v.pc = 1; v.ir = 1; v.ill = pend_ill; v.err = pend_err;
    exp_q.push_back(v);
    v = '0;
    exp_q.push_back(v);
    if (op > 7 || low == 7) begin
      nxt_ill = 1;
      return;
    end
    v = '0;
    case (low)
      0, 1: v.us = 1;
      3:    v.us = 1;
      4:    v.uop = 3'b110;
      5:    begin v.j = 1; v.pc = 1; end
      6:    begin v.uop = 3'b111; v.j = 1; v.b = 1; v.pc = 1; end
      default: ;
    endcase
    exp_q.push_back(v);
    if (low == 5 || low == 6) begin
      nxt_ret = 1;
      return;
    end
    if (low <= 1) begin
      mem_len = (wait_n >= TO) ? TO : wait_n + 1;
      v = '0; v.mr = (low == 0); v.mw = (low == 1);
      repeat (mem_len) exp_q.push_back(v);
      if (wait_n >= TO) begin
        nxt_err = 1;
        return;
      end
      if (low == 1) begin
        nxt_ret = 1;
        return;
      end
    end
    v = '0; v.rw = 1; v.rs = (low != 0);
    exp_q.push_back(v);
    nxt_ret = 1;
  endfunction

  // Runs one instruction (optionally freezing after cycle freeze_at), checking every cycle.
  task automatic run_instr(input logic [OW-1:0] op, input int unsigned wait_n,
                           input int freeze_at, input int unsigned freeze_len);
    vec_t fv;
    build(op, wait_n);
    for (int i = 0; i < int'(exp_q.size()); i++) begin
      checks++;
      if (observed() !== exp_q[i]) begin
        errors++;
        $display("FAIL outputs op=%0h cycle=%0d: got %b want %b", op, i, observed(), exp_q[i]);
      end
      checks++;
      if (instr_count !== CW'(exp_count)) begin
        errors++;
        $display("FAIL instr_count op=%0h cycle=%0d: got %0d want %0d", op, i, instr_count, exp_count);
      end
      if (i == freeze_at) begin
        fv = exp_q[i];
        fv.pc = 0; fv.ir = 0; fv.rw = 0; fv.mw = 0; fv.ill = 0; fv.err = 0;
        for (int k = 0; k < int'(freeze_len); k++) begin
          enable    = 1'b0;
          opcode    = OW'($urandom);
          mem_ready = 1'($urandom);
          step();
          checks++;
          if (observed() !== fv) begin
            errors++;
            $display("FAIL frozen op=%0h cycle=%0d: got %b want %b", op, i, observed(), fv);
          end
        end
        enable = 1'b1;
      end
      opcode = (i == 1) ? op : OW'($urandom);
      if (i >= 3 && (i - 3) < int'(mem_len)) mem_ready = ((i - 3) >= int'(wait_n));
      else mem_ready = 1'($urandom);
      step();
    end
    pend_ill = nxt_ill;
    pend_err = nxt_err;
`ifdef UC_INSTR_COUNT_EN
    if (nxt_ret) exp_count = (exp_count + 1) % (1 << CW);
`endif
  endtask

  task automatic apply_reset();
    #2 reset = 1'b0;
    @(posedge clock);
    #3 reset = 1'b1;
    step();
    exp_count = 0; pend_ill = 0; pend_err = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; opcode = '0; mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (observed() !== vec_t'('0)) begin
        errors++;
        $display("FAIL reset_outputs: got %b want 0", observed());
      end
      checks++;
      if (instr_count !== '0) begin
        errors++;
        $display("FAIL reset_count: got %0d want 0", instr_count);
      end
    end
    #2 reset = 1'b1;
    step();
  endtask

  task automatic test_add();       run_instr(4'd2, 0, -1, 0);   endtask
  task automatic test_lw_wait();   run_instr(4'd0, 3, -1, 0);   endtask
  task automatic test_sw_timeout(); run_instr(4'd1, 100, -1, 0); endtask

  task automatic test_illegal();
    run_instr(4'd7, 0, -1, 0);
    run_instr(4'b1010, 0, -1, 0);
    run_instr(4'd3, 0, -1, 0);
  endtask

  task automatic test_reset_mid();
    opcode = '0; mem_ready = 1'b0;
    repeat (4) step();
    checks++;
    if (mem_read !== 1'b1) begin
      errors++;
      $display("FAIL lw_mem_read_before_reset: got %b want 1", mem_read);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (observed() !== vec_t'('0)) begin
      errors++;
      $display("FAIL async_reset_outputs: got %b want 0", observed());
    end
    checks++;
    if (instr_count !== '0) begin
      errors++;
      $display("FAIL async_reset_count: got %0d want 0", instr_count);
    end
    @(posedge clock);
    #3 reset = 1'b1;
    step();
    exp_count = 0; pend_ill = 0; pend_err = 0;
    run_instr(4'd0, 0, -1, 0);
  endtask

  task automatic test_enable();
    run_instr(4'd6, 0, 2, 2);
    run_instr(4'd0, 2, 4, 3);
    run_instr(4'd1, 1, 1, 2);
  endtask

  task automatic test_wrap();
    logic [CW-1:0] want;
    apply_reset();
    for (int n = 0; n < 17; n++) run_instr(4'd2, 0, -1, 0);
`ifdef UC_INSTR_COUNT_EN
    want = CW'(1);
`else
    want = '0;
`endif
    checks++;
    if (instr_count !== want) begin
      errors++;
      $display("FAIL count_wrap: got %0d want %0d", instr_count, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] op;
    int unsigned   w;
    int            fz;
    for (int n = 0; n < 60; n++) begin
      op = OW'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) op[OW-1] = 1'b1;
      w  = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
      fz = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_instr(op, w, fz, $urandom_range(1, 3));
    end
    run_instr(4'd5, 0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_sw_timeout();
    test_illegal();
    test_reset_mid();
    test_enable();
    test_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
